// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-master fixed-priority arbiter for the SDRAM Avalon-MM slave
// Port 0 has priority; a starvation counter forces a handover to port 1 after STARVE_LIMIT cycles.
module sdram_port_arbiter #(
    parameter int ADDR_W       = 25,
    parameter int MAX_PEND     = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [15:0]       p0_writedata,
    input  logic [1:0]        p0_byteenable,
    output logic              p0_waitrequest,
    output logic [15:0]       p0_readdata,
    output logic              p0_readdatavalid,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [15:0]       p1_writedata,
    input  logic [1:0]        p1_byteenable,
    output logic              p1_waitrequest,
    output logic [15:0]       p1_readdata,
    output logic              p1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [15:0]       s_writedata,
    output logic [1:0]        s_byteenable,
    input  logic              s_waitrequest,
    input  logic [15:0]       s_readdata,
    input  logic              s_readdatavalid,
    output logic              err_unexp_rdv
);
    localparam int PW = $clog2(MAX_PEND + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

    state_t        state;
    logic          owner;
    logic          force_p1;
    logic [PW-1:0] pend;
    logic [SW-1:0] starve;

    logic p0_req, p1_req, own0, own1, full, accept, rdv_ok;

    assign p0_req = p0_read | p0_write;
    assign p1_req = p1_read | p1_write;
    assign own0   = (state == OWN0);
    assign own1   = (state == OWN1);
    assign full   = (pend == PW'(MAX_PEND));

    // Command mux follows the owner register; only OWNx states actually issue commands.
    assign s_address    = owner ? p1_address    : p0_address;
    assign s_writedata  = owner ? p1_writedata  : p0_writedata;
    assign s_byteenable = owner ? p1_byteenable : p0_byteenable;
    assign s_read       = ((own0 & p0_read) | (own1 & p1_read)) & ~full;
    assign s_write      = (own0 & p0_write) | (own1 & p1_write);

    assign p0_waitrequest = own0 ? (s_waitrequest | (p0_read & full)) : 1'b1;
    assign p1_waitrequest = own1 ? (s_waitrequest | (p1_read & full)) : 1'b1;

    assign accept = s_read & ~s_waitrequest;
    assign rdv_ok = s_readdatavalid & (pend != '0);

    assign p0_readdata      = s_readdata;
    assign p1_readdata      = s_readdata;
    assign p0_readdatavalid = rdv_ok & ~owner;
    assign p1_readdatavalid = rdv_ok & owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            force_p1      <= 1'b0;
            pend          <= '0;
            starve        <= '0;
            err_unexp_rdv <= 1'b0;
        end else begin
            if (s_readdatavalid && pend == '0)
                err_unexp_rdv <= 1'b1;

            if (accept && !rdv_ok)
                pend <= pend + PW'(1);
            else if (!accept && rdv_ok)
                pend <= pend - PW'(1);

            if (!p1_req)
                starve <= '0;

            case (state)
                IDLE: begin
                    if (p0_req) begin
                        state <= OWN0;
                        owner <= 1'b0;
                    end else if (p1_req) begin
                        state  <= OWN1;
                        owner  <= 1'b1;
                        starve <= '0;
                    end
                end
                OWN0: begin
                    if (p1_req && starve != SW'(STARVE_LIMIT))
                        starve <= starve + SW'(1);
                    if (p1_req && starve >= SW'(STARVE_LIMIT - 1)) begin
                        state    <= DRAIN;
                        force_p1 <= 1'b1;
                    end else if (!p0_req) begin
                        state <= DRAIN;
                    end
                end
                OWN1: begin
                    if (!p1_req)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Owner stays put until outstanding reads have returned to it.
                    if (pend == '0) begin
                        if (force_p1) begin
                            state    <= OWN1;
                            owner    <= 1'b1;
                            force_p1 <= 1'b0;
                            starve   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] p0_address, p1_address, s_address;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [15:0] p0_writedata, p1_writedata, s_writedata;
    logic [1:0]  p0_byteenable, p1_byteenable, s_byteenable;
    logic        p0_waitrequest, p1_waitrequest;
    logic [15:0] p0_readdata, p1_readdata;
    logic        p0_readdatavalid, p1_readdatavalid;
    logic        s_read, s_write, s_waitrequest;
    logic [15:0] s_readdata;
    logic        s_readdatavalid;
    logic        err_unexp_rdv;

    logic        man_rdv;
    logic [15:0] man_rdata;
    logic        auto_mem = 1'b0;
    logic [7:0]  sh_v = '0;
    logic [15:0] sh_d [8];
    logic [15:0] acc_cnt = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_address(p0_address), .p0_read(p0_read), .p0_write(p0_write),
        .p0_writedata(p0_writedata), .p0_byteenable(p0_byteenable),
        .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata),
        .p0_readdatavalid(p0_readdatavalid),
        .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write),
        .p1_writedata(p1_writedata), .p1_byteenable(p1_byteenable),
        .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata),
        .p1_readdatavalid(p1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .err_unexp_rdv(err_unexp_rdv)
    );

    // SDRAM stand-in: each accepted read returns 0xC000+n exactly 8 cycles later.
    always @(posedge clk) begin
        if (auto_mem) begin
            sh_v    <= {sh_v[6:0], s_read & ~s_waitrequest};
            sh_d[0] <= 16'hC000 + acc_cnt;
            for (int i = 1; i < 8; i++) sh_d[i] <= sh_d[i-1];
            if (s_read && !s_waitrequest) acc_cnt <= acc_cnt + 16'd1;
        end
    end

    assign s_readdatavalid = auto_mem ? sh_v[7] : man_rdv;
    assign s_readdata      = auto_mem ? sh_d[7] : man_rdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int issued, got;
    logic saw_stall, p1_bad;

    initial begin
        reset = 1'b1;
        p0_address = '0; p0_read = 0; p0_write = 0; p0_writedata = '0; p0_byteenable = '0;
        p1_address = '0; p1_read = 0; p1_write = 0; p1_writedata = '0; p1_byteenable = '0;
        s_waitrequest = 1'b0; man_rdv = 1'b0; man_rdata = '0;
        step(); step(); #1;
        chk("rst_p0_wait", p0_waitrequest, 1);
        chk("rst_p1_wait", p1_waitrequest, 1);
        chk("rst_s_read", s_read, 0);
        chk("rst_s_write", s_write, 0);
        chk("rst_err", err_unexp_rdv, 0);
        chk("rst_p0_rdv", p0_readdatavalid, 0);
        chk("rst_pend", dut.pend, 0);
        reset = 1'b0;
        step();

        // single p0 read
        p0_address = 25'h000100; p0_read = 1; #1;
        chk("t1_idle_no_fwd", s_read, 0);
        chk("t1_idle_wait", p0_waitrequest, 1);
        step(); #1;
        chk("t1_s_read", s_read, 1);
        chk("t1_s_addr", s_address, 32'h100);
        chk("t1_p0_go", p0_waitrequest, 0);
        step();
        p0_read = 0; man_rdv = 1; man_rdata = 16'hA5A5; #1;
        chk("t1_p0_rdv", p0_readdatavalid, 1);
        chk("t1_p0_data", p0_readdata, 32'hA5A5);
        chk("t1_p1_rdv", p1_readdatavalid, 0);
        step(); man_rdv = 0; #1;
        chk("t1_pend0", dut.pend, 0);
        step(); step();

        // simultaneous requests: p0 wins
        p0_write = 1; p0_address = 25'h10; p0_writedata = 16'h5555; p0_byteenable = 2'b11;
        p1_read = 1; p1_address = 25'h20; #1;
        chk("t2_idle_no_wr", s_write, 0);
        step(); #1;
        chk("t2_s_write", s_write, 1);
        chk("t2_s_addr", s_address, 32'h10);
        chk("t2_s_be", s_byteenable, 3);
        chk("t2_p0_go", p0_waitrequest, 0);
        chk("t2_p1_wait", p1_waitrequest, 1);
        chk("t2_no_p1_rd", s_read, 0);
        step(); p0_write = 0; #1;
        chk("t2_p1_wait2", p1_waitrequest, 1);
        step(); #1;
        chk("t2_drain_rd", s_read, 0);
        chk("t2_drain_wait", p1_waitrequest, 1);
        step(); #1;
        chk("t2_idle_rd", s_read, 0);
        step(); #1;
        chk("t2_p1_read", s_read, 1);
        chk("t2_p1_addr", s_address, 32'h20);
        chk("t2_p1_go", p1_waitrequest, 0);
        step();
        p1_read = 0; man_rdv = 1; man_rdata = 16'h7E57; #1;
        chk("t2_p1_rdv", p1_readdatavalid, 1);
        chk("t2_p1_data", p1_readdata, 32'h7E57);
        chk("t2_p0_rdv", p0_readdatavalid, 0);
        step(); man_rdv = 0;
        step(); step();

        // starvation: p0 streams reads, p1 holds a write
        p1_write = 1; p1_address = 25'h0000FF; p1_writedata = 16'h1234; p1_byteenable = 2'b11;
        p0_read = 1; p0_address = 25'h200;
        step();
        for (int k = 1; k <= 64; k++) begin
            #1;
            chk("t3_p1_wait", p1_waitrequest, 1);
            chk("t3_s_read", s_read, (k <= 4) ? 1 : 0);
            step();
        end
        #1;
        chk("t3_drain_rd", s_read, 0);
        chk("t3_p0_masked", p0_waitrequest, 1);
        chk("t3_drain_pend", dut.pend, 4);
        chk("t3_drain_wr", s_write, 0);
        for (int d = 0; d < 4; d++) begin
            man_rdv = 1; man_rdata = 16'h1000 + 16'(d); #1;
            chk("t3_p0_rdv", p0_readdatavalid, 1);
            chk("t3_p0_data", p0_readdata, 32'h1000 + d);
            step();
        end
        man_rdv = 0; #1;
        chk("t3_pend0", dut.pend, 0);
        chk("t3_wr_not_yet", s_write, 0);
        step(); #1;
        chk("t3_p1_write", s_write, 1);
        chk("t3_p1_addr", s_address, 32'hFF);
        chk("t3_p1_wdata", s_writedata, 32'h1234);
        chk("t3_p1_go", p1_waitrequest, 0);
        chk("t3_p0_stall", p0_waitrequest, 1);
        step();
        p1_write = 0; p0_read = 0;
        step(); step(); step();

        // 8-cycle read latency, 6 reads, pend cap 4
        auto_mem = 1; issued = 0; got = 0; saw_stall = 0; p1_bad = 0;
        p0_read = 1; p0_address = 25'h300;
        step();
        for (int c = 0; c < 40; c++) begin
            p0_read = (issued < 6);
            #1;
            if (p0_read && p0_waitrequest && dut.pend == 4 && issued == 4) saw_stall = 1;
            if (p0_read && !p0_waitrequest) issued++;
            if (p0_readdatavalid) begin
                chk("t4_order", p0_readdata, 32'hC000 + got);
                got++;
            end
            if (p1_readdatavalid) p1_bad = 1;
            step();
        end
        chk("t4_issued", issued, 6);
        chk("t4_got", got, 6);
        chk("t4_stall_at4", saw_stall, 1);
        chk("t4_p1_quiet", p1_bad, 0);
        chk("t4_pend0", dut.pend, 0);
        auto_mem = 0;
        step();

        // accept and return in the same cycle
        p1_read = 1; p1_address = 25'h40;
        step(); step(); step();
        man_rdv = 1; man_rdata = 16'hBEEF; #1;
        chk("t5_pend2_pre", dut.pend, 2);
        chk("t5_p1_rdv", p1_readdatavalid, 1);
        chk("t5_p0_rdv", p0_readdatavalid, 0);
        chk("t5_p1_go", p1_waitrequest, 0);
        step(); #1;
        chk("t5_pend2_post", dut.pend, 2);
        p1_read = 0;
        step(); step();
        man_rdv = 0; #1;
        chk("t5_pend0", dut.pend, 0);
        chk("t5_err0", err_unexp_rdv, 0);
        step(); step();

        // unexpected readdatavalid, then reset mid-transfer
        man_rdv = 1; man_rdata = 16'hDEAD; #1;
        chk("t6_rdv_ignored0", p0_readdatavalid, 0);
        chk("t6_rdv_ignored1", p1_readdatavalid, 0);
        step(); man_rdv = 0; #1;
        chk("t6_err_set", err_unexp_rdv, 1);
        step(); step(); #1;
        chk("t6_err_sticky", err_unexp_rdv, 1);
        p0_read = 1;
        step(); step(); step(); step(); #1;
        chk("t6_pend3", dut.pend, 3);
        reset = 1; #1;
        chk("t6_rst_pend", dut.pend, 0);
        chk("t6_rst_p0_wait", p0_waitrequest, 1);
        chk("t6_rst_p1_wait", p1_waitrequest, 1);
        chk("t6_rst_err", err_unexp_rdv, 0);
        chk("t6_rst_rd", s_read, 0);
        p0_read = 0; man_rdv = 1;
        step(); #1;
        chk("t6_err_in_rst", err_unexp_rdv, 0);
        man_rdv = 0; reset = 0;
        step();
        man_rdv = 1; #1;
        chk("t6_late_rdv", p0_readdatavalid, 0);
        step(); man_rdv = 0; #1;
        chk("t6_err_after", err_unexp_rdv, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
